// File: rtl/seq_sort_calc.sv
// seq_sort_calc: insertion-sorts a DEPTH-number frame and streams one of four reductions.
// Define SEQ_SORT_CALC_ABORT_EN to add the frame_abort pulse output.
module seq_sort_calc #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 6,
  parameter int OUT_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_number,
  input  logic        [1:0]        mode,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_result
`ifdef SEQ_SORT_CALC_ABORT_EN
  ,
  output logic                     frame_abort
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_chk_depth
      $fatal(1, "seq_sort_calc: DEPTH must be >= 2");
    end
    if (OUT_W < DATA_W + $clog2(DEPTH)) begin : g_chk_outw
      $fatal(1, "seq_sort_calc: OUT_W must be >= DATA_W + clog2(DEPTH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;
  logic        [1:0]         r_mode;
  logic        [CNT_W-1:0]   r_in_cnt;
  logic        [CNT_W-1:0]   r_out_cnt;
  logic signed [DATA_W-1:0]  r_sort [DEPTH];
  logic signed [OUT_W-1:0]   r_pre  [DEPTH];
  logic signed [OUT_W-1:0]   r_sum;
  logic                      r_out_valid;
  logic signed [OUT_W-1:0]   r_out_result;

  logic        [CNT_W-1:0]   w_n;
  logic        [DEPTH-1:0]   w_gt;
  logic signed [DATA_W-1:0]  w_ins  [DEPTH];
  logic signed [DATA_W-1:0]  w_src  [DEPTH];
  logic signed [OUT_W-1:0]   w_x;
  logic signed [OUT_W-1:0]   w_sum_nx;
  logic        [CNT_W-1:0]   w_idx;
  logic        [CNT_W-1:0]   w_nbeats;
  logic signed [DATA_W-1:0]  w_asc;
  logic signed [DATA_W-1:0]  w_desc;
  logic signed [OUT_W-1:0]   w_pre;
  logic signed [DATA_W:0]    w_diff;
  logic signed [OUT_W-1:0]   w_sel;
  logic                      w_out_valid_nx;
  logic signed [OUT_W-1:0]   w_out_result_nx;
`ifdef SEQ_SORT_CALC_ABORT_EN
  logic                      r_abort;
  logic                      w_abort_nx;
`endif

  assign w_x      = OUT_W'(in_number);
  assign w_sum_nx = r_sum + w_x;
  assign w_nbeats = (r_mode == 2'd3) ? C_ONE : C_FULL;

  // Entries strictly greater than the new value move up one slot, so equal
  // values land after existing equals; an IDLE beat sees an empty buffer.
  always_comb begin
    w_n = (r_state == LOAD) ? r_in_cnt : '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_gt[i] = (CNT_W'(i) < w_n) && (r_sort[i] > in_number);
    end
    w_ins[0] = (w_gt[0] || (w_n == '0)) ? in_number : r_sort[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (w_gt[i-1]) begin
        w_ins[i] = r_sort[i-1];
      end else if (w_gt[i] || (CNT_W'(i) == w_n)) begin
        w_ins[i] = in_number;
      end else begin
        w_ins[i] = r_sort[i];
      end
    end
  end

  // On the final load beat the first result is taken from the freshly inserted
  // array so out_valid can rise the very next cycle.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_src[i] = (r_state == OUT) ? r_sort[i] : w_ins[i];
    end
    w_idx  = (r_state == OUT) ? r_out_cnt : '0;
    w_asc  = '0;
    w_desc = '0;
    w_pre  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == w_idx) begin
        w_asc  = w_src[i];
        w_desc = w_src[DEPTH-1-i];
        w_pre  = r_pre[i];
      end
    end
    w_diff = {w_src[DEPTH-1][DATA_W-1], w_src[DEPTH-1]} - {w_src[0][DATA_W-1], w_src[0]};
    case (r_mode)
      2'd0:    w_sel = OUT_W'(w_asc);
      2'd1:    w_sel = OUT_W'(w_desc);
      2'd2:    w_sel = w_pre;
      default: w_sel = OUT_W'(w_diff);
    endcase
  end

  always_comb begin
    w_state_nx      = r_state;
    w_out_valid_nx  = 1'b0;
    w_out_result_nx = '0;
`ifdef SEQ_SORT_CALC_ABORT_EN
    w_abort_nx      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nx = LOAD;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          w_state_nx = IDLE;
`ifdef SEQ_SORT_CALC_ABORT_EN
          w_abort_nx = 1'b1;
`endif
        end else if (r_in_cnt == C_LAST) begin
          w_state_nx      = OUT;
          w_out_valid_nx  = 1'b1;
          w_out_result_nx = w_sel;
        end
      end
      OUT: begin
        if (r_out_cnt == w_nbeats) begin
          w_state_nx = IDLE;
        end else begin
          w_out_valid_nx  = 1'b1;
          w_out_result_nx = w_sel;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_sum        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sort[i] <= '0;
        r_pre[i]  <= '0;
      end
    end else begin
      r_out_valid  <= w_out_valid_nx;
      r_out_result <= w_out_result_nx;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode   <= mode;
            r_in_cnt <= C_ONE;
            r_sum    <= w_x;
            r_pre[0] <= w_x;
            for (int unsigned i = 0; i < DEPTH; i++) begin
              r_sort[i] <= w_ins[i];
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_in_cnt  <= r_in_cnt + C_ONE;
            r_sum     <= w_sum_nx;
            r_out_cnt <= C_ONE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
              r_sort[i] <= w_ins[i];
              if (CNT_W'(i) == r_in_cnt) begin
                r_pre[i] <= w_sum_nx;
              end
            end
          end else begin
            r_in_cnt <= '0;
          end
        end
        OUT: begin
          if (w_out_valid_nx) begin
            r_out_cnt <= r_out_cnt + C_ONE;
          end else begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_SORT_CALC_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_abort_nx;
    end
  end

  assign frame_abort = r_abort;
`endif

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;

endmodule

// File: tb/tb_seq_sort_calc.sv
// Scoreboard bench for seq_sort_calc: driver queues expected results, monitor pops and compares.
`timescale 1ns/1ps
module tb_seq_sort_calc;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 6;
  localparam int OUT_W  = 7;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_number = '0;
  logic        [1:0]        mode = '0;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_result;
`ifdef SEQ_SORT_CALC_ABORT_EN
  logic                     frame_abort;
`endif

  typedef struct {
    int val;
    int cyc;
    int tag;
  } exp_t;

  typedef int vec_t [6];

  exp_t sb [$];
  vec_t va;
  vec_t ve;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   abort_hi = 0;
  int   ab0;

  seq_sort_calc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_number  (in_number),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_result (out_result)
`ifdef SEQ_SORT_CALC_ABORT_EN
    ,
    .frame_abort(frame_abort)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_out frame%0d: got no beat by cycle %0d expected %0d at cycle %0d",
                 sb[0].tag, cyc, sb[0].val, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %0d at cycle %0d expected no beat", int'(out_result), cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("frame%0d_value", e.tag), int'(out_result), e.val);
          chk($sformatf("frame%0d_cycle", e.tag), cyc, e.cyc);
        end
      end else begin
        chk("idle_result_zero", int'(out_result), 0);
      end
`ifdef SEQ_SORT_CALC_ABORT_EN
      if (frame_abort === 1'b1) abort_hi++;
`endif
    end
  end

  // Caller is at a negedge; later beats carry a different mode to prove it is latched.
  task automatic send(input logic [1:0] m, input int nb, input int ne, input int tag);
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      in_valid  = 1'b1;
      in_number = DATA_W'(va[i]);
      mode      = (i == 0) ? m : ~m;
      if (i == nb - 1) begin
        for (int j = 0; j < ne; j++) begin
          e.val = ve[j];
          e.cyc = cyc + 1 + j;
          e.tag = tag;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_number = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_result", int'(out_result), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    va = '{3, -2, 7, 0, -8, 5};     ve = '{-8, -2, 0, 3, 5, 7};
    send(2'd0, 6, 6, 1); idle(6);
    ve = '{7, 5, 3, 0, -2, -8};
    send(2'd1, 6, 6, 2); idle(6);
    va = '{-8, -8, -8, -8, -8, -8}; ve = '{-8, -16, -24, -32, -40, -48};
    send(2'd2, 6, 6, 3); idle(6);
    va = '{7, 7, 7, 7, 7, 7};       ve = '{7, 14, 21, 28, 35, 42};
    send(2'd2, 6, 6, 4); idle(6);
    va = '{-8, 7, 1, 1, 1, 1};      ve = '{15, 0, 0, 0, 0, 0};
    send(2'd3, 6, 1, 5); idle(1);
    va = '{4, 4, 4, 4, 4, 4};       ve = '{0, 0, 0, 0, 0, 0};
    send(2'd3, 6, 1, 6); idle(1);

    ab0 = abort_hi;
    va = '{1, 2, 3, 0, 0, 0};
    send(2'd0, 3, 0, 7); idle(3);
`ifdef SEQ_SORT_CALC_ABORT_EN
    chk("frame_abort_pulse_len", abort_hi - ab0, 1);
`endif
    va = '{5, -1, 5, -3, 2, 0};     ve = '{-3, -1, 0, 2, 5, 5};
    send(2'd0, 6, 6, 8); idle(6);

    // Reset lands just after the third output beat has been sampled.
    va = '{6, -4, 2, -7, 0, 3};     ve = '{-7, -4, 0, 2, 3, 6};
    send(2'd0, 6, 6, 9);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midout_reset_valid", int'(out_valid), 0);
    chk("midout_reset_result", int'(out_result), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    va = '{-1, 4, -6, 2, 7, -3};    ve = '{7, 4, 2, -1, -3, -6};
    send(2'd1, 6, 6, 10);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_number = DATA_W'(-8 + i);
      mode      = 2'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle(3);

    va = '{2, -5, 3, 0, 1, -1};     ve = '{8, 0, 0, 0, 0, 0};
    send(2'd3, 6, 1, 11); idle(1);

    idle(10);
    chk("scoreboard_drained", sb.size(), 0);
`ifdef SEQ_SORT_CALC_ABORT_EN
    chk("frame_abort_total", abort_hi, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
